// File: rtl/sw_pio_irq_servicer.sv
// sw_pio_irq_servicer: Avalon-MM master servicing a switch PIO interrupt with holdoff debounce
module sw_pio_irq_servicer #(
  parameter logic [31:0] IRQ_MASK_VALUE = 32'd1,
  parameter int unsigned HOLDOFF_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 irq,
  input  logic [31:0]          readdata,
  output logic [1:0]           address,
  output logic                 chipselect,
  output logic                 write_n,
  output logic [31:0]          writedata,
  output logic                 evt_valid,
  output logic                 evt_level,
  output logic [CNT_WIDTH-1:0] evt_count,
  output logic                 busy
);
  typedef enum logic [2:0] {INIT, IDLE, CLR, RD_ADDR, RD_WAIT, HOLD} state_e;
  localparam logic [15:0] HOLD_LAST = (HOLDOFF_CYCLES == 0) ? 16'd0 : 16'(HOLDOFF_CYCLES - 1);
  state_e                 state_q, state_d;
  logic [15:0]            hold_q, hold_d;
  logic [1:0]             addr_q, addr_d;
  logic                   cs_q, cs_d, wn_q, wn_d, ev_q, ev_d, lvl_q, lvl_d, busy_q, busy_d;
  logic [31:0]            wd_q, wd_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   rd_unused;
  assign rd_unused = ^readdata[31:1];
  // next state; INIT holds until its mask write has been presented on the bus
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    state_d = cs_q ? IDLE : INIT;
      IDLE:    state_d = (irq && enable) ? CLR : IDLE;
      CLR:     state_d = RD_ADDR;
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: state_d = HOLD;
      HOLD:    state_d = (hold_q == HOLD_LAST) ? IDLE : HOLD;
      default: state_d = INIT;
    endcase
  end
  // registered outputs decoded from the upcoming state so the bus lines up with the state
  always_comb begin
    hold_d = (state_q == HOLD) ? hold_q + 16'd1 : '0;
    addr_d = (state_d == INIT) ? 2'd2 : (state_d == CLR) ? 2'd3 : 2'd0;
    cs_d   = state_d inside {INIT, CLR, RD_ADDR, RD_WAIT};
    wn_d   = !(state_d inside {INIT, CLR});
    wd_d   = (state_d == INIT) ? IRQ_MASK_VALUE : '0;
    ev_d   = state_q == RD_WAIT;
    lvl_d  = (state_q == RD_WAIT) ? readdata[0] : lvl_q;
    cnt_d  = cnt_q + CNT_WIDTH'(state_q == RD_WAIT);
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      hold_q  <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wd_q    <= '0;
      ev_q    <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
      ev_q    <= ev_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
  assign address    = addr_q;
  assign chipselect = cs_q;
  assign write_n    = wn_q;
  assign writedata  = wd_q;
  assign evt_valid  = ev_q;
  assign evt_level  = lvl_q;
  assign evt_count  = cnt_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_sw_pio_irq_servicer.sv
// tb_sw_pio_irq_servicer: directed vector table plus slave-model sequences for sw_pio_irq_servicer
module tb_sw_pio_irq_servicer;
  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, use_model = 1'b0, tb_irq = 1'b0;
  logic [31:0] tb_rd = '0;
  logic        irq;
  logic [31:0] readdata;
  logic [1:0]  address;
  logic        chipselect, write_n, evt_valid, evt_level, busy;
  logic [31:0] writedata;
  logic [7:0]  evt_count;
  int          n_chk = 0, n_fail = 0, bus_acc = 0;
  logic        sw = 1'b0, sw_q = 1'b0, cap_m = 1'b0;
  logic [31:0] mask_m = '0, rd_m = '0;
  logic        m_irq;

  sw_pio_irq_servicer #(.IRQ_MASK_VALUE(32'd1), .HOLDOFF_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq), .readdata(readdata),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .evt_valid(evt_valid), .evt_level(evt_level), .evt_count(evt_count), .busy(busy));

  always #5 clk = ~clk;

  assign m_irq    = cap_m & mask_m[0];
  assign irq      = use_model ? m_irq : tb_irq;
  assign readdata = use_model ? rd_m : tb_rd;

  // switch PIO slave: rising edge capture, write-to-clear, registered reads
  always @(posedge clk) begin
    sw_q    <= sw;
    cap_m   <= (sw & ~sw_q) | (cap_m & ~(chipselect && !write_n && address == 2'd3));
    if (chipselect && !write_n && address == 2'd2) mask_m <= writedata;
    rd_m    <= (chipselect && write_n && address == 2'd0) ? {31'h2AAAAAAA, sw} : 32'h0;
    if (chipselect) bus_acc <= bus_acc + 1;
  end

  typedef struct {
    logic        irq;
    logic        en;
    logic [31:0] rd;
    logic [46:0] exp;
  } vec_t;
  vec_t tbl[22];

  function automatic vec_t mk(logic i, logic e, logic [31:0] r, logic [1:0] a, logic c, logic w,
                              logic [31:0] d, logic ev, logic l, logic [7:0] n, logic b);
    vec_t t;
    t.irq = i;
    t.en  = e;
    t.rd  = r;
    t.exp = {a, c, w, d, ev, l, n, b};
    return t;
  endfunction

  function automatic logic [46:0] obs();
    return {address, chipselect, write_n, writedata, evt_valid, evt_level, evt_count, busy};
  endfunction

  localparam logic [46:0] RST_OUT  = {2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1};
  localparam logic [46:0] INIT_OUT = {2'd2, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0, 8'd0, 1'b1};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_evt(output int n);
    n = 0;
    while (n < 30 && !evt_valid) begin
      tick();
      n++;
    end
    chk("evt_valid_seen", 64'(evt_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 30 && busy) begin
      tick();
      n++;
    end
    chk("busy_drop", 64'(busy), 64'd0);
  endtask

  task automatic edge_sw();
    sw = 1'b0;
    tick();
    sw = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, snap, exp_cnt;
    logic evt_seen;
    tbl[0]  = mk(0, 1, 32'h0,        2'd2, 1, 0, 32'd1, 0, 0, 8'd0, 1);
    tbl[1]  = mk(0, 1, 32'h0,        2'd0, 0, 1, 32'd0, 0, 0, 8'd0, 0);
    tbl[2]  = mk(0, 1, 32'h0,        2'd0, 0, 1, 32'd0, 0, 0, 8'd0, 0);
    tbl[3]  = mk(1, 1, 32'h0,        2'd3, 1, 0, 32'd0, 0, 0, 8'd0, 1);
    tbl[4]  = mk(0, 1, 32'h0,        2'd0, 1, 1, 32'd0, 0, 0, 8'd0, 1);
    tbl[5]  = mk(0, 1, 32'h0,        2'd0, 1, 1, 32'd0, 0, 0, 8'd0, 1);
    tbl[6]  = mk(0, 1, 32'h1,        2'd0, 0, 1, 32'd0, 1, 1, 8'd1, 1);
    tbl[7]  = mk(0, 1, 32'h0,        2'd0, 0, 1, 32'd0, 0, 1, 8'd1, 1);
    tbl[8]  = mk(0, 1, 32'h0,        2'd0, 0, 1, 32'd0, 0, 1, 8'd1, 1);
    tbl[9]  = mk(0, 1, 32'h0,        2'd0, 0, 1, 32'd0, 0, 1, 8'd1, 1);
    tbl[10] = mk(0, 1, 32'h0,        2'd0, 0, 1, 32'd0, 0, 1, 8'd1, 0);
    tbl[11] = mk(1, 0, 32'h0,        2'd0, 0, 1, 32'd0, 0, 1, 8'd1, 0);
    tbl[12] = mk(1, 0, 32'h0,        2'd0, 0, 1, 32'd0, 0, 1, 8'd1, 0);
    tbl[13] = mk(1, 1, 32'h0,        2'd3, 1, 0, 32'd0, 0, 1, 8'd1, 1);
    tbl[14] = mk(0, 1, 32'h0,        2'd0, 1, 1, 32'd0, 0, 1, 8'd1, 1);
    tbl[15] = mk(0, 1, 32'h0,        2'd0, 1, 1, 32'd0, 0, 1, 8'd1, 1);
    tbl[16] = mk(0, 1, 32'hFFFFFFFE, 2'd0, 0, 1, 32'd0, 1, 0, 8'd2, 1);
    tbl[17] = mk(1, 0, 32'h0,        2'd0, 0, 1, 32'd0, 0, 0, 8'd2, 1);
    tbl[18] = mk(1, 0, 32'h0,        2'd0, 0, 1, 32'd0, 0, 0, 8'd2, 1);
    tbl[19] = mk(1, 0, 32'h0,        2'd0, 0, 1, 32'd0, 0, 0, 8'd2, 1);
    tbl[20] = mk(1, 1, 32'h0,        2'd0, 0, 1, 32'd0, 0, 0, 8'd2, 0);
    tbl[21] = mk(1, 1, 32'h0,        2'd3, 1, 0, 32'd0, 0, 0, 8'd2, 1);

    tick();
    tick();
    chk("reset_values", 64'(obs()), 64'(RST_OUT));
    reset_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tb_irq = tbl[i].irq;
      enable = tbl[i].en;
      tb_rd  = tbl[i].rd;
      tick();
      chk($sformatf("vec%0d", i), 64'(obs()), 64'(tbl[i].exp));
    end

    reset_n = 1'b0;
    use_model = 1'b1;
    enable = 1'b1;
    sw = 1'b0;
    tick();
    chk("model_reset", 64'(obs()), 64'(RST_OUT));
    reset_n = 1'b1;
    tick();
    chk("init_write", 64'(obs()), 64'(INIT_OUT));
    tick();
    chk("after_init", 64'({busy, chipselect, evt_count}), 64'({1'b0, 1'b0, 8'd0}));
    chk("slave_mask", 64'(mask_m), 64'd1);

    sw = 1'b1;
    tick();
    wait_evt(n);
    chk("irq_to_evt_latency", 64'(n), 64'd4);
    chk("svc1_level_count", 64'({evt_level, evt_count}), 64'({1'b1, 8'd1}));
    snap = bus_acc;
    edge_sw();
    wait_idle();
    chk("hold_bus_quiet", 64'(bus_acc - snap), 64'd0);
    chk("hold_irq_kept", 64'(irq), 64'd1);
    wait_evt(n);
    chk("svc2_latency", 64'(n), 64'd4);
    chk("svc2_level_count", 64'({evt_level, evt_count}), 64'({1'b1, 8'd2}));

    wait_idle();
    enable = 1'b0;
    edge_sw();
    snap = bus_acc;
    repeat (50) tick();
    chk("disabled_no_bus", 64'(bus_acc - snap), 64'd0);
    chk("disabled_idle_irq", 64'({busy, irq}), 64'({1'b0, 1'b1}));
    enable = 1'b1;
    tick();
    chk("enable_starts_clr", 64'({address, chipselect, write_n}), 64'({2'd3, 1'b1, 1'b0}));
    wait_evt(n);
    chk("svc3_count", 64'(evt_count), 64'd3);

    exp_cnt = 3;
    while (exp_cnt < 256) begin
      wait_idle();
      edge_sw();
      wait_evt(n);
      exp_cnt++;
      if (exp_cnt == 255) chk("count_255", 64'(evt_count), 64'd255);
    end
    chk("count_wrap", 64'(evt_count), 64'd0);

    wait_idle();
    edge_sw();
    tick();
    tick();
    tick();
    chk("in_rd_wait", 64'({address, chipselect, write_n}), 64'({2'd0, 1'b1, 1'b1}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_now", 64'(obs()), 64'(RST_OUT));
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("init_reissued", 64'(obs()), 64'(INIT_OUT));
    evt_seen = 1'b0;
    repeat (12) begin
      tick();
      if (evt_valid) evt_seen = 1'b1;
    end
    chk("aborted_no_evt", 64'({evt_seen, evt_count}), 64'({1'b0, 8'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
